// File: rtl/jmp_unit.sv
// Conditional jump unit: snapshots the ALU flags, fetches a 2-byte target and pulses a PC load when taken.
// Optional REL_JUMP_EN: rel=1 jumps fetch one signed byte that is added to pc_in.
module jmp_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        cond,
    input  logic              rel,
    input  logic              zflag,
    input  logic              oflag,
    input  logic              cflag,
    input  logic              sflag,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [7:0]        mem_data,
    input  logic              mem_valid,
    output logic              mem_req,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              done,
    output logic              taken
);
    typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, DECIDE} state_t;

    state_t            state, state_nxt;
    logic              armed;
    logic [3:0]        cond_q;
    logic [3:0]        flg_q;    // {z, o, c, s}
    logic [7:0]        lo_q, hi_q;
    logic [ADDR_W-1:0] pc_q;
    logic              taken_q;
    logic              cond_ok;
    logic              rel_mode;
    logic              go;
    logic [ADDR_W-1:0] abs_tgt, target;
    logic              fz, fo, fc, fs;

    // armed blocks a start that coincides with reset release
    assign go      = (state == IDLE) && start && armed;
    assign abs_tgt = {hi_q[ADDR_W-9:0], lo_q};
    assign {fz, fo, fc, fs} = flg_q;

`ifdef REL_JUMP_EN
    logic rel_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    rel_q <= 1'b0;
        else if (go) rel_q <= rel;
    end

    assign rel_mode = rel_q;
    assign target   = rel_q ? pc_in + {{(ADDR_W-8){lo_q[7]}}, lo_q} : abs_tgt;
`else
    logic unused_rel;
    assign unused_rel = ^{rel, pc_in};
    assign rel_mode   = 1'b0;
    assign target     = abs_tgt;
`endif

    always_comb begin
        cond_ok = 1'b0;
        case (cond_q)
            4'd0:    cond_ok = 1'b1;
            4'd1:    cond_ok = fz;
            4'd2:    cond_ok = !fz;
            4'd3:    cond_ok = fc;
            4'd4:    cond_ok = !fc;
            4'd5:    cond_ok = fs;
            4'd6:    cond_ok = !fs;
            4'd7:    cond_ok = fo;
            4'd8:    cond_ok = !fo;
            4'd9:    cond_ok = !fc && !fz;
            4'd10:   cond_ok = fc || fz;
            4'd11:   cond_ok = (fs == fo);
            4'd12:   cond_ok = (fs != fo);
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        pc_inc    = 1'b0;
        done      = 1'b0;
        pc_load   = 1'b0;
        case (state)
            IDLE: if (go) state_nxt = FETCH_LO;
            FETCH_LO: begin
                mem_req = 1'b1;
                if (mem_valid) begin
                    pc_inc    = 1'b1;
                    state_nxt = rel_mode ? DECIDE : FETCH_HI;
                end
            end
            FETCH_HI: begin
                mem_req = 1'b1;
                if (mem_valid) begin
                    pc_inc    = 1'b1;
                    state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                done      = 1'b1;
                pc_load   = cond_ok;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy   = (state != IDLE);
    assign taken  = (state == DECIDE) ? cond_ok : taken_q;
    assign pc_out = pc_load ? target : pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            armed   <= 1'b0;
            cond_q  <= '0;
            flg_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            pc_q    <= '0;
            taken_q <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (go) begin
                cond_q  <= cond;
                flg_q   <= {zflag, oflag, cflag, sflag};
                taken_q <= 1'b0;
            end
            if (state == FETCH_LO && mem_valid) lo_q <= mem_data;
            if (state == FETCH_HI && mem_valid) hi_q <= mem_data;
            if (done) begin
                taken_q <= cond_ok;
                if (cond_ok) pc_q <= target;
            end
        end
    end
endmodule

// File: tb/tb_jmp_unit.sv
// Scoreboard bench for jmp_unit: expectations queued at start, checked on done.
module tb_jmp_unit;
    logic        clk = 1'b0;
    logic        rst, start, rel, mem_valid;
    logic [3:0]  cond;
    logic        zflag, oflag, cflag, sflag;
    logic [15:0] pc_in;
    logic [7:0]  mem_data;
    logic        mem_req, pc_inc, pc_load, busy, done, taken;
    logic [15:0] pc_out;

    jmp_unit #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .cond(cond), .rel(rel),
        .zflag(zflag), .oflag(oflag), .cflag(cflag), .sflag(sflag),
        .pc_in(pc_in), .mem_data(mem_data), .mem_valid(mem_valid),
        .mem_req(mem_req), .pc_inc(pc_inc), .pc_load(pc_load), .pc_out(pc_out),
        .busy(busy), .done(done), .taken(taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tk;
        logic [15:0] pc;
        int          incs;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          nvec = 0, nmis = 0;
    int          cyc = 0, start_cyc = 0, inc_cnt = 0, done_cnt = 0;
    int          bidx = 0, stall_cnt = 0;
    logic        mv_en = 1'b0;
    logic [7:0]  bytes [0:1];
    logic [15:0] model_pc = 16'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic z, o, cf, s;
        {z, o, cf, s} = f;
        case (c)
            4'd0:    return 1'b1;
            4'd1:    return z;
            4'd2:    return !z;
            4'd3:    return cf;
            4'd4:    return !cf;
            4'd5:    return s;
            4'd6:    return !s;
            4'd7:    return o;
            4'd8:    return !o;
            4'd9:    return !cf && !z;
            4'd10:   return cf || z;
            4'd11:   return s == o;
            4'd12:   return s != o;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // memory responder: presents the current operand byte, optional stall on the high byte
    always @(posedge clk) begin
        #1;
        mem_data = (bidx < 2) ? bytes[bidx] : 8'h00;
        if (mem_req && bidx == 1 && stall_cnt > 0) begin
            mem_valid = 1'b0;
            stall_cnt--;
        end else begin
            mem_valid = mv_en;
        end
    end

    // output monitor
    always @(negedge clk) begin
        exp_t e;
        if (start && !busy) begin
            start_cyc = cyc;
            inc_cnt   = 0;
        end
        if (pc_inc) begin
            inc_cnt++;
            bidx++;
            if (!mem_req) chk("pc_inc_without_req", 1, 0);
        end
        if (pc_load && !done) chk("pc_load_without_done", 1, 0);
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("taken", taken, e.tk);
                chk("pc_load", pc_load, e.tk);
                chk("pc_out", pc_out, e.pc);
                chk("pc_inc_count", inc_cnt, e.incs);
                chk("latency", cyc - start_cyc, e.lat);
            end
        end
    end

    // f = {z,o,c,s}; flags are inverted right after start to prove the snapshot
    task automatic jump(input logic [3:0] c, input logic r, input logic [3:0] f,
                        input logic [7:0] lo, input logic [7:0] hi,
                        input int stall, input logic restart);
        exp_t        e;
        logic        tk, r_eff;
        logic [15:0] tgt;
        int          d0;
        bit          seen;
`ifdef REL_JUMP_EN
        r_eff = r;
`else
        r_eff = 1'b0;
`endif
        tk  = cond_ok(c, f);
        tgt = r_eff ? pc_in + {{8{lo[7]}}, lo} : {hi, lo};
        if (tk) model_pc = tgt;
        e.tk = tk; e.pc = model_pc; e.incs = r_eff ? 1 : 2;
        e.lat = (r_eff ? 2 : 3) + stall;
        exp_q.push_back(e);
        bytes[0] = lo; bytes[1] = hi; bidx = 0; stall_cnt = stall;
        d0 = done_cnt;
        @(posedge clk); #1;
        cond = c; rel = r; {zflag, oflag, cflag, sflag} = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; {zflag, oflag, cflag, sflag} = ~f;
        if (restart) begin
            @(posedge clk); #1;
            start = 1'b1; cond = 4'd0;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("busy_held", busy, 1);
            chk("mem_req_held", mem_req, 1);
        end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done_cnt != d0) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; cond = 4'd0; rel = 1'b0; pc_in = 16'h0;
        {zflag, oflag, cflag, sflag} = 4'h0;
        mem_data = 8'h00; mem_valid = 1'b0;
        bytes[0] = 8'h00; bytes[1] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {mem_req, pc_inc, pc_load, busy, done, taken}, 0);
        chk("reset_pc_out", pc_out, 0);

        // start coinciding with reset release is dropped
        @(posedge clk); #1; rst = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("start_at_release", busy, 0);
        mv_en = 1'b1;

        jump(4'd0,  1'b0, 4'b0000, 8'h34, 8'h12, 0, 1'b0);
        jump(4'd1,  1'b0, 4'b0000, 8'hAB, 8'hCD, 0, 1'b0);
        jump(4'd12, 1'b0, 4'b0001, 8'h78, 8'h56, 0, 1'b0);
        jump(4'd12, 1'b0, 4'b0101, 8'h11, 8'h22, 0, 1'b0);
        jump(4'd15, 1'b0, 4'b1111, 8'h33, 8'h44, 0, 1'b0);
        for (int i = 0; i < 16; i++)
            jump(i[3:0], 1'b0, 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 1'b0);
        jump(4'd0, 1'b0, 4'b0000, 8'hEF, 8'hBE, 5, 1'b1);

        // rel=1: relative with the feature, plain absolute without it
        pc_in = 16'h0100;
        jump(4'd0, 1'b1, 4'b0000, 8'hFE, 8'h9A, 0, 1'b0);
        pc_in = 16'hFFFF;
        jump(4'd0, 1'b1, 4'b0000, 8'h02, 8'h7C, 0, 1'b0);

        // reset while waiting in FETCH_HI
        bytes[0] = 8'hAA; bytes[1] = 8'hBB; bidx = 0; stall_cnt = 20;
        @(posedge clk); #1; cond = 4'd0; rel = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midop_reset_ctrl", {mem_req, pc_inc, pc_load, busy, done, taken}, 0);
        chk("midop_reset_pc_out", pc_out, 0);
        @(posedge clk); #1; rst = 1'b1; stall_cnt = 0; model_pc = 16'h0;
        jump(4'd2, 1'b0, 4'b1000, 8'h55, 8'h66, 0, 1'b0);
        jump(4'd9, 1'b0, 4'b0000, 8'h21, 8'h43, 0, 1'b0);

        if (exp_q.size() != 0) chk("leftover_expectations", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/jmp_unit.md
Name: jmp_unit

Overview:
- Consumer of the ALU flag register (zflag/oflag/cflag/sflag).
- On a jump instruction it samples the flags and fetches the target address as two operand bytes from the 8-bit memory bus.
- It evaluates the branch condition and, if the branch is taken, issues a one-cycle PC load.
- Sits between the instruction decoder, the flag register, memory and the PC.

Parameters:
- ADDR_W, 16, PC width. Legal range 9..16. Target = {hi[ADDR_W-9:0], lo}; unused hi bits are dropped.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  decoder request to execute a jump; 1-cycle pulse.
- cond  in  4  condition code, sampled with start.
- rel  in  1  relative-jump select, sampled with start. Used only with REL_JUMP_EN.
- zflag, oflag, cflag, sflag  in  1 each  flags from the flag register.
- pc_in  in  ADDR_W  current PC. Used only with REL_JUMP_EN.
- mem_data  in  8  operand byte from memory.
- mem_valid  in  1  mem_data valid; accepted only while mem_req=1.
- mem_req  out  1  operand byte request.
- pc_inc  out  1  1-cycle pulse per accepted byte; PC steps past the operand.
- pc_load  out  1  1-cycle pulse; PC takes pc_out.
- pc_out  out  ADDR_W  jump target.
- busy  out  1  high from the cycle after start until done.
- done  out  1  1-cycle pulse at completion.
- taken  out  1  condition result; valid with done, held until the next start.

Behaviour:
- Reset (rst=0, any time, including mid-operation): state IDLE. mem_req, pc_inc, pc_load, busy, done and taken = 0; pc_out = 0; latched cond, flags and bytes cleared.
- States: IDLE, FETCH_LO, FETCH_HI, DECIDE.
- IDLE: on start=1, latch cond, rel and a snapshot of all four flags, then go to FETCH_LO. Flag changes after this edge are ignored.
- FETCH_LO: mem_req=1. On mem_valid=1, latch lo and pulse pc_inc the same cycle, then go to FETCH_HI. No timeout; waits indefinitely.
- FETCH_HI: same handshake; latch hi, then go to DECIDE.
- DECIDE (one cycle):
  - done=1 and taken updated.
  - If taken: pc_load=1 and pc_out=target in the same cycle.
  - If not taken: pc_load=0 and pc_out keeps its old value. Operand bytes are still consumed so the PC skips them.
  - Next state IDLE.
- Minimum latency from start to done: 3 cycles with mem_valid already high.
- Condition codes (evaluated on the snapshot):
  - 0 always
  - 1 z
  - 2 !z
  - 3 c
  - 4 !c
  - 5 s
  - 6 !s
  - 7 o
  - 8 !o
  - 9 !c&!z (unsigned >)
  - 10 c|z (unsigned <=)
  - 11 s==o (signed >=)
  - 12 s!=o (signed <)
  - 13-15 never; completes with taken=0.
- start while busy, or in the DECIDE cycle: ignored, not queued.
- mem_valid outside FETCH_*: ignored, no pc_inc.
- start and reset released in the same cycle: start is ignored.

Optional Feature:
- Macro REL_JUMP_EN.
- Defined, when rel=1 is latched:
  - FETCH_LO goes directly to DECIDE; only one byte is fetched.
  - Target = pc_in, sampled in the DECIDE cycle, plus the sign-extended lo byte, modulo 2^ADDR_W.
  - Latency drops by one cycle.
- Defined, when rel=0: absolute behaviour as above.
- Not defined: the rel and pc_in ports still exist but are ignored, and all jumps are absolute.

Test Plan:
- Reset then cond=0, bytes 0x34,0x12, mem_valid held high -> exactly 2 pc_inc pulses; done 3 cycles after start; pc_load=1 with pc_out=0x1234; taken=1.
- cond=1 with zflag=0 at start, zflag driven to 1 during fetch -> taken=0, no pc_load, pc_out unchanged, 2 pc_inc pulses.
- cond=12 with s=1,o=0 -> taken=1; repeat with s=1,o=1 -> taken=0; cond=15 -> taken=0.
- mem_valid low 5 cycles in FETCH_HI, plus a second start pulse while busy -> mem_req held, busy held, the second start has no effect, a single done pulse.
- rst asserted during FETCH_HI -> all outputs 0 on the next observation; a subsequent jump runs cleanly from IDLE.
- With REL_JUMP_EN: rel=1, pc_in=0x0100, byte 0xFE -> 1 pc_inc, pc_out=0x00FE, done 2 cycles after start; pc_in=0xFFFF, byte 0x02 -> pc_out=0x0001.
